// File: rtl/sw_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sw_ctrl_pkg : shared state encoding and default timing constants for the |
// |               stopwatch control slice (stopwatch_ctrl, btn_debounce).     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package sw_ctrl_pkg;

   typedef logic [1:0] sw_state_t;

   localparam logic [1:0] C_ST_IDLE  = 2'b00;
   localparam logic [1:0] C_ST_RUN   = 2'b01;
   localparam logic [1:0] C_ST_LAP   = 2'b10;
   localparam logic [1:0] C_ST_PAUSE = 2'b11;

   localparam int C_DB_TICKS_DFLT   = 4;
   localparam int C_LONG_TICKS_DFLT = 1000;
   localparam int C_LT_W_DFLT       = 10;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_ctrl_if : control bundle between stopwatch_ctrl (master) and   |
// |                     the clock divider / time-counter chain (slave).      |
// |                     lap_num exists only with STOPWATCH_LAP_COUNT_EN.     |
// | Revision          : 1.0                                                  |
// +--------------------------------------------------------------------------+
interface stopwatch_ctrl_if;
   import sw_ctrl_pkg::*;

   logic      div_en;
   logic      time_clr;
   logic      disp_hold;
   logic      running;
   sw_state_t state;
   logic      time_max;

`ifdef STOPWATCH_LAP_COUNT_EN
   logic [3:0] lap_num;

   modport master (
      output div_en, time_clr, disp_hold, running, state, lap_num,
      input  time_max
   );
   modport slave (
      input  div_en, time_clr, disp_hold, running, state, lap_num,
      output time_max
   );
`else
   modport master (
      output div_en, time_clr, disp_hold, running, state,
      input  time_max
   );
   modport slave (
      input  div_en, time_clr, disp_hold, running, state,
      output time_max
   );
`endif

endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl_btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_debounce : 2-FF synchronizer, tick-sampled debounce counter and      |
// |                one-clk press pulse on a rising stable level.             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module btn_debounce
   import sw_ctrl_pkg::*;
#(
   parameter int DB_TICKS = C_DB_TICKS_DFLT
) (
   input  logic clk,
   input  logic reset,
   input  logic tick_ref,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int              C_CW     = $clog2(DB_TICKS + 1);
   localparam logic [C_CW-1:0] C_DB_MAX = C_CW'(DB_TICKS);

   logic [1:0]      r_sync;
   logic            r_prev;
   logic            r_stable;
   logic            r_stable_d;
   logic [C_CW-1:0] r_cnt;
   logic [C_CW-1:0] w_cnt_nxt;

   // Run length of equal consecutive samples, saturating so it stays "accepted".
   always_comb begin
      w_cnt_nxt = '0;
      if (r_sync[1] == r_prev)
         w_cnt_nxt = (r_cnt == C_DB_MAX) ? r_cnt : r_cnt + C_CW'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync     <= '0;
         r_prev     <= 1'b0;
         r_cnt      <= '0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], btn_raw};
         r_stable_d <= r_stable;
         if (tick_ref) begin
            r_prev <= r_sync[1];
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == C_DB_MAX)
               r_stable <= r_sync[1];
         end
      end
   end

   assign level = r_stable;
   assign press = r_stable & ~r_stable_d;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stopwatch_ctrl : run/lap/pause/clear FSM for the stopwatch time base,    |
// |                  with long-press clear. Optional STOPWATCH_LAP_COUNT_EN  |
// |                  adds a decimal lap counter on the interface.            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module stopwatch_ctrl
   import sw_ctrl_pkg::*;
#(
   parameter int DB_TICKS   = C_DB_TICKS_DFLT,
   parameter int LONG_TICKS = C_LONG_TICKS_DFLT,
   parameter int LT_W       = C_LT_W_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick_ref,
   input  logic             btn_ss,
   input  logic             btn_lc,
   stopwatch_ctrl_if.master tc
);

   localparam logic [LT_W-1:0] C_LONG_MAX = LT_W'(LONG_TICKS);

   logic            w_ss_press;
   logic            w_ss_level;
   logic            w_lc_press;
   logic            w_lc_level;
   logic            w_long_hit;
   sw_state_t       w_state_nxt;
   sw_state_t       r_state;
   logic            r_active;
   logic            r_disp_hold;
   logic            r_time_clr;
   logic [LT_W-1:0] r_long_cnt;

   btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_ss (
      .clk      (clk),
      .reset    (reset),
      .tick_ref (tick_ref),
      .btn_raw  (btn_ss),
      .level    (w_ss_level),
      .press    (w_ss_press)
   );

   btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_lc (
      .clk      (clk),
      .reset    (reset),
      .tick_ref (tick_ref),
      .btn_raw  (btn_lc),
      .level    (w_lc_level),
      .press    (w_lc_press)
   );

   assign w_long_hit = (r_state == C_ST_PAUSE) && (r_long_cnt == C_LONG_MAX);

   // time_max outranks buttons; ss is tested before lc so a same-cycle pair keeps ss.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_IDLE: begin
            if (w_ss_press)
               w_state_nxt = C_ST_RUN;
         end
         C_ST_RUN: begin
            if (tc.time_max || w_ss_press)
               w_state_nxt = C_ST_PAUSE;
            else if (w_lc_press)
               w_state_nxt = C_ST_LAP;
         end
         C_ST_LAP: begin
            if (tc.time_max || w_ss_press)
               w_state_nxt = C_ST_PAUSE;
            else if (w_lc_press)
               w_state_nxt = C_ST_RUN;
         end
         C_ST_PAUSE: begin
            if (w_long_hit)
               w_state_nxt = C_ST_IDLE;
            else if (w_ss_press && !tc.time_max)
               w_state_nxt = C_ST_RUN;
         end
         default: w_state_nxt = C_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= C_ST_IDLE;
         r_active    <= 1'b0;
         r_disp_hold <= 1'b0;
         r_time_clr  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_active    <= (w_state_nxt == C_ST_RUN) || (w_state_nxt == C_ST_LAP);
         r_disp_hold <= (w_state_nxt == C_ST_LAP);
         r_time_clr  <= w_long_hit;
      end
   end

   // Held at zero outside PAUSE, so every PAUSE entry starts a fresh count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_long_cnt <= '0;
      else if ((r_state != C_ST_PAUSE) || !w_lc_level)
         r_long_cnt <= '0;
      else if (tick_ref && (r_long_cnt != C_LONG_MAX))
         r_long_cnt <= r_long_cnt + LT_W'(1);
   end

   assign tc.div_en    = r_active;
   assign tc.running   = r_active;
   assign tc.disp_hold = r_disp_hold;
   assign tc.time_clr  = r_time_clr;
   assign tc.state     = r_state;

`ifdef STOPWATCH_LAP_COUNT_EN
   logic [3:0] r_lap_num;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_lap_num <= 4'd0;
      else if (w_long_hit)
         r_lap_num <= 4'd0;
      else if ((r_state == C_ST_RUN) && (w_state_nxt == C_ST_LAP))
         r_lap_num <= (r_lap_num == 4'd9) ? 4'd0 : r_lap_num + 4'd1;
   end

   assign tc.lap_num = r_lap_num;
`endif

endmodule
`default_nettype wire
